cell_dispatch: RTL and testbench

Multi-engine cell distributor between the frame fetch unit and `IP_AMT` HOG/SVM engines. It accepts one cell stream (valid/ready) and either deals cells round-robin across engines or broadcasts every cell to all engines. Each engine has its own FIFO, and every cell carries a linear frame index tag. It replaces the single point-to-point `cell_data`/`cell_valid`/`cell_ready` link in the SoC top.

---
 rtl/cell_pkg.sv | 14 +
 rtl/cell_fifo.sv | 70 +++++++
 rtl/cell_dispatch.sv | 88 ++++++++
 tb/tb_cell_dispatch.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cell_pkg.sv
// Shared constants for the cell dispatch slice: cell geometry, frame size,
// index tag width and the distribution mode encoding.
package cell_pkg;

    localparam int CELL_WIDTH     = 768;
    localparam int FRAME_ROW_CNUM = 30;
    localparam int FRAME_COL_CNUM = 40;
    localparam int CELL_NUM       = FRAME_ROW_CNUM * FRAME_COL_CNUM;
    localparam int IDX_W          = $clog2(CELL_NUM);

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_BCAST = 1'b1;

endpackage

// File: rtl/cell_fifo.sv
// First-word-fall-through FIFO with registered full/empty flags.
// The head is forced to zero while empty so idle engines see clean outputs.
module cell_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr_q, rdPtr_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full_q, empty_q;
    logic             doPush, doPop;

    assign doPush = push_i && !full_q;
    assign doPop  = pop_i && !empty_q;

    always_comb begin
        cnt_d = cnt_q;
        if (doPush && !doPop) begin
            cnt_d = CW'(cnt_q + 1);
        end else if (!doPush && doPop) begin
            cnt_d = CW'(cnt_q - 1);
        end
    end

    // Flags are computed from the next count, so a pop from a full FIFO
    // only opens space on the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (doPush) begin
                wrPtr_q <= AW'(wrPtr_q + 1);
            end
            if (doPop) begin
                rdPtr_q <= AW'(rdPtr_q + 1);
            end
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CW'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr_q] <= data_i;
        end
    end

    assign data_o  = empty_q ? '0 : mem[rdPtr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/cell_dispatch.sv
// Distributes one upstream cell stream over IP_AMT engine FIFOs, either
// round-robin or broadcast, tagging every cell with its index in the frame.
module cell_dispatch #(
    parameter int CELL_WIDTH     = cell_pkg::CELL_WIDTH,
    parameter int IP_AMT         = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int FRAME_ROW_CNUM = cell_pkg::FRAME_ROW_CNUM,
    parameter int FRAME_COL_CNUM = cell_pkg::FRAME_COL_CNUM,
    parameter int IDX_W          = $clog2(FRAME_ROW_CNUM * FRAME_COL_CNUM)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mode_i,
    input  logic [CELL_WIDTH-1:0]        s_cell_data_i,
    input  logic                         s_cell_valid_i,
    output logic                         s_cell_ready_o,
    output logic [IP_AMT*CELL_WIDTH-1:0] m_cell_data_o,
    output logic [IP_AMT*IDX_W-1:0]      m_cell_idx_o,
    output logic [IP_AMT-1:0]            m_cell_valid_o,
    input  logic [IP_AMT-1:0]            m_cell_ready_i,
    output logic                         frame_done_o
);

    import cell_pkg::*;

    localparam int PTR_W    = (IP_AMT > 1) ? $clog2(IP_AMT) : 1;
    localparam int LAST_IDX = FRAME_ROW_CNUM * FRAME_COL_CNUM - 1;

    logic [IDX_W-1:0]  idx_q;
    logic [PTR_W-1:0]  rrPtr_q;
    logic              mode_q;
    logic              frameDone_q;
    logic [IP_AMT-1:0] full, empty, push;
    logic              upXfer, lastCell;

    // Round-robin never skips a full target so cell n always lands on engine n mod IP_AMT.
    assign s_cell_ready_o = (mode_q == MODE_BCAST) ? ~|full : ~full[rrPtr_q];
    assign upXfer         = s_cell_valid_i && s_cell_ready_o;
    assign lastCell       = (idx_q == IDX_W'(LAST_IDX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= '0;
            rrPtr_q     <= '0;
            mode_q      <= MODE_RR;
            frameDone_q <= 1'b0;
        end else begin
            frameDone_q <= upXfer && lastCell;
            if (upXfer) begin
                idx_q <= lastCell ? '0 : IDX_W'(idx_q + 1);
                if (lastCell) begin
                    rrPtr_q <= '0;
                end else if (mode_q == MODE_RR) begin
                    rrPtr_q <= (rrPtr_q == PTR_W'(IP_AMT - 1)) ? '0 : PTR_W'(rrPtr_q + 1);
                end
            end else if (idx_q == '0) begin
                mode_q <= mode_i;
            end
        end
    end

    for (genvar k = 0; k < IP_AMT; k++) begin : gEng
        logic [CELL_WIDTH+IDX_W-1:0] head;

        assign push[k] = upXfer && ((mode_q == MODE_BCAST) || (rrPtr_q == PTR_W'(k)));

        cell_fifo #(
            .WIDTH(CELL_WIDTH + IDX_W),
            .DEPTH(FIFO_DEPTH)
        ) uFifo (
            .clk    (clk),
            .rst    (rst),
            .push_i (push[k]),
            .data_i ({idx_q, s_cell_data_i}),
            .pop_i  (m_cell_ready_i[k]),
            .data_o (head),
            .full_o (full[k]),
            .empty_o(empty[k])
        );

        assign m_cell_data_o[k*CELL_WIDTH +: CELL_WIDTH] = head[CELL_WIDTH-1:0];
        assign m_cell_idx_o[k*IDX_W +: IDX_W]            = head[CELL_WIDTH +: IDX_W];
    end

    assign m_cell_valid_o = ~empty;
    assign frame_done_o   = frameDone_q;

endmodule

// File: tb/tb_cell_dispatch.sv
// Directed bench for cell_dispatch: round-robin, backpressure, broadcast,
// frame wrap with a mid-frame mode toggle, and asynchronous reset.
module tb_cell_dispatch;

    import cell_pkg::*;

    localparam int NENG = 2;
    localparam int CW   = CELL_WIDTH;
    localparam int IW   = IDX_W;
    localparam logic [31:0] BASE = 32'hC0DE_0000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 mode_i;
    logic [CW-1:0]        s_cell_data_i;
    logic                 s_cell_valid_i;
    logic                 s_cell_ready_o;
    logic [NENG*CW-1:0]   m_cell_data_o;
    logic [NENG*IW-1:0]   m_cell_idx_o;
    logic [NENG-1:0]      m_cell_valid_o;
    logic [NENG-1:0]      m_cell_ready_i;
    logic                 frame_done_o;

    int errors = 0;
    int checks = 0;
    int seq = 0;
    int firstStall, doneCount, doneSeq;
    int q0[$];
    int q1[$];
    int stallValid, stallIdx0, stallIdx1, stallReady, stallDataEq;
    logic [CW-1:0] monData;
    logic [31:0]   monWord;
    int            monIdx, monSeq;

    always #5 clk = ~clk;

    cell_dispatch #(
        .IP_AMT    (NENG),
        .FIFO_DEPTH(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mode_i        (mode_i),
        .s_cell_data_i (s_cell_data_i),
        .s_cell_valid_i(s_cell_valid_i),
        .s_cell_ready_o(s_cell_ready_o),
        .m_cell_data_o (m_cell_data_o),
        .m_cell_idx_o  (m_cell_idx_o),
        .m_cell_valid_o(m_cell_valid_o),
        .m_cell_ready_i(m_cell_ready_i),
        .frame_done_o  (frame_done_o)
    );

    function automatic logic [CW-1:0] mkCell(input int n);
        logic [31:0] w;
        w = BASE + 32'(n);
        return {(CW/32){w}};
    endfunction

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkSeq(input string tag, input int q[$], input int start,
                            input int step, input int n);
        checkOutput({tag, "Len"}, q.size(), n);
        for (int i = 0; i < n && i < q.size(); i++) begin
            checkOutput(tag, q[i], start + i * step);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Asserts reset mid-cycle and checks outputs before any clock edge.
    task automatic resetDut(input logic m);
        mode_i         = m;
        s_cell_valid_i = 1'b0;
        m_cell_ready_i = '0;
        #2 rst = 1'b1;
        #1;
        checkOutput("rstValid", int'(m_cell_valid_o), 0);
        checkOutput("rstData",  (m_cell_data_o == '0) ? 1 : 0, 1);
        checkOutput("rstIdx",   int'(m_cell_idx_o), 0);
        checkOutput("rstDone",  int'(frame_done_o), 0);
        checkOutput("rstReady", int'(s_cell_ready_o), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        seq = 0;
        q0.delete();
        q1.delete();
        doneCount = 0;
        doneSeq   = -1;
    endtask

    // Offers nCells consecutive cells; after three stalled cycles it snapshots
    // the outputs and switches the engine readies to relReady.
    task automatic applyStimulus(input int nCells, input logic [NENG-1:0] relReady);
        int   sent = 0;
        int   stallCycles = 0;
        int   budget = 0;
        logic acc;
        firstStall = -1;
        while (sent < nCells && budget < 5000) begin
            s_cell_valid_i = 1'b1;
            s_cell_data_i  = mkCell(seq);
            acc = s_cell_ready_o;
            if (!acc) begin
                if (firstStall < 0) firstStall = seq;
                stallCycles++;
                if (stallCycles == 3) begin
                    stallValid     = int'(m_cell_valid_o);
                    stallIdx0      = int'(m_cell_idx_o[0 +: IW]);
                    stallIdx1      = int'(m_cell_idx_o[IW +: IW]);
                    stallReady     = int'(s_cell_ready_o);
                    stallDataEq    = (m_cell_data_o[0 +: CW] == m_cell_data_o[CW +: CW]) ? 1 : 0;
                    m_cell_ready_i = relReady;
                end
            end
            @(posedge clk);
            #1;
            if (acc) begin
                seq++;
                sent++;
            end
            budget++;
        end
        s_cell_valid_i = 1'b0;
        if (sent < nCells) checkOutput("sendTimeout", sent, nCells);
    endtask

    // Records every engine transfer and checks its tag against the payload.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int k = 0; k < NENG; k++) begin
                if (m_cell_valid_o[k] && m_cell_ready_i[k]) begin
                    monData = m_cell_data_o[k*CW +: CW];
                    monWord = monData[31:0];
                    monSeq  = int'(monWord - BASE);
                    monIdx  = int'(m_cell_idx_o[k*IW +: IW]);
                    checkOutput("engIdxTag", monIdx, monSeq % CELL_NUM);
                    checkOutput("engDataRep", (monData == mkCell(monSeq)) ? 1 : 0, 1);
                    if (k == 0) q0.push_back(monIdx);
                    else        q1.push_back(monIdx);
                end
            end
            if (frame_done_o) begin
                doneCount++;
                doneSeq = seq;
            end
        end
    end

    initial begin
        rst            = 1'b0;
        mode_i         = 1'b0;
        s_cell_valid_i = 1'b0;
        s_cell_data_i  = '0;
        m_cell_ready_i = '0;

        $display("[TB] round-robin streaming");
        resetDut(1'b0);
        m_cell_ready_i = 2'b11;
        idle(1);
        applyStimulus(6, 2'b11);
        checkOutput("rrNoStall", firstStall, -1);
        checkOutput("rrLatValid", int'(m_cell_valid_o), 2);
        checkOutput("rrLatIdx1", int'(m_cell_idx_o[IW +: IW]), 5);
        idle(3);
        checkSeq("rrQ0", q0, 0, 2, 3);
        checkSeq("rrQ1", q1, 1, 2, 3);

        $display("[TB] round-robin backpressure");
        resetDut(1'b0);
        m_cell_ready_i = 2'b01;
        idle(1);
        applyStimulus(12, 2'b11);
        checkOutput("bpFirstStall", firstStall, 9);
        checkOutput("bpStallReady", stallReady, 0);
        checkOutput("bpStallValid", stallValid, 2);
        checkOutput("bpStallHead1", stallIdx1, 1);
        idle(6);
        checkSeq("bpQ0", q0, 0, 2, 6);
        checkSeq("bpQ1", q1, 1, 2, 6);

        $display("[TB] broadcast");
        resetDut(1'b1);
        m_cell_ready_i = 2'b00;
        idle(1);
        applyStimulus(6, 2'b11);
        checkOutput("bcFirstStall", firstStall, 4);
        checkOutput("bcStallReady", stallReady, 0);
        checkOutput("bcStallValid", stallValid, 3);
        checkOutput("bcStallHead0", stallIdx0, 0);
        checkOutput("bcStallHead1", stallIdx1, 0);
        checkOutput("bcDataEqual", stallDataEq, 1);
        idle(6);
        checkSeq("bcQ0", q0, 0, 1, 6);
        checkSeq("bcQ1", q1, 0, 1, 6);

        $display("[TB] frame wrap with mid-frame mode toggle");
        resetDut(1'b0);
        m_cell_ready_i = 2'b11;
        idle(1);
        applyStimulus(600, 2'b11);
        mode_i = 1'b1;
        applyStimulus(600, 2'b11);
        applyStimulus(1, 2'b11);
        idle(3);
        checkOutput("wrapDoneCount", doneCount, 1);
        checkOutput("wrapDoneCycle", doneSeq, 1200);
        checkOutput("wrapQ0Len", q0.size(), 601);
        checkOutput("wrapQ1Len", q1.size(), 600);
        checkOutput("wrapQ0Last", (q0.size() > 600) ? q0[600] : -1, 0);
        checkOutput("wrapQ1Last", (q1.size() > 599) ? q1[599] : -1, 1199);

        $display("[TB] reset mid-operation");
        resetDut(1'b0);
        m_cell_ready_i = 2'b00;
        idle(1);
        applyStimulus(3, 2'b00);
        checkOutput("preRstValid", int'(m_cell_valid_o), 3);
        resetDut(1'b0);
        m_cell_ready_i = 2'b11;
        idle(1);
        checkOutput("postRstReady", int'(s_cell_ready_o), 1);
        applyStimulus(1, 2'b11);
        idle(2);
        checkOutput("postRstQ0Len", q0.size(), 1);
        checkOutput("postRstQ0Idx", (q0.size() > 0) ? q0[0] : -1, 0);
        checkOutput("postRstQ1Len", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
